leddc_serial_rx: RTL and testbench
==================================

// Module: leddc_serial_rx
// PURPOSE
//   Front-end deserializer for the LED display driver. It shifts the DAI serial grey-level
//   stream into 16-bit words while DEN is high, and writes each complete word into a
//   double-banked frame buffer. When a full frame has been received it swaps the banks
//   and tells the PWM/scan stage (GCK domain) which bank holds the newest frame.
// PARAMETERS
//   DATA_W           16   bits per grey-level word (one channel of one scanline)
//   WORDS_PER_FRAME  512  words per frame (32 scanlines x 16 channels)
//   ADDR_W           9    log2(WORDS_PER_FRAME); width of word address within a bank
// PORTS
//   DCK         in   1              data clock; all state updates on posedge
//   rst         in   1              synchronous reset, active-high
//   DAI         in   1              serial data; sampled on posedge DCK when DEN=1; LSB first
//   DEN         in   1              data enable; frames one or more back-to-back words
//   wr_en       out  1              frame-buffer write strobe, 1 cycle per word
//   wr_addr     out  ADDR_W+1       {bank, word_idx}; word_idx = scanline*16 + channel
//   wr_data     out  DATA_W         assembled word (first sampled bit = bit 0)
//   frame_done  out  1              1-cycle pulse coincident with the write of the last word of a frame
//   disp_bank   out  1              bank holding the most recent complete frame (read by PWM stage)
//   frag_err    out  1              1-cycle pulse: DEN fell with a partial word pending
// BEHAVIOUR
//   Reset (rst=1 at posedge DCK) dominates every other event. It clears all state.
//     Outputs after reset: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, disp_bank=1, frag_err=0.
//     Internal state after reset: write bank=0, word_idx=0, bit_cnt=0, FSM=IDLE.
//   FSM states:
//     IDLE:
//       DEN=1 -> sample DAI into bit 0, bit_cnt=1, go to SHIFT.
//       DEN=0 -> stay in IDLE.
//     SHIFT:
//       DEN=1 -> sample DAI into bit[bit_cnt], bit_cnt++.
//         On the DATA_W-th sample, go to COMMIT and bit_cnt=0.
//       DEN=0 -> discard the partial word, pulse frag_err next cycle, bit_cnt=0, go to IDLE.
//         word_idx is not advanced.
//     COMMIT (exactly 1 cycle):
//       wr_en=1, wr_addr={bank, word_idx}, wr_data=word. word_idx++.
//       DEN=1 -> DAI is sampled as bit 0 of the next word, bit_cnt=1, go to SHIFT.
//         Back-to-back words lose no bits.
//       DEN=0 -> go to IDLE.
//   Latency: wr_en is high in the cycle after the edge that sampled bit DATA_W-1.
//   Outputs are registered; wr_addr and wr_data are held when wr_en=0.
//   Frame wrap: in the COMMIT where word_idx = WORDS_PER_FRAME-1:
//     frame_done=1 in that cycle; word_idx wraps to 0.
//     Next cycle: disp_bank <= bank, and bank <= ~bank.
//     Words of the next frame therefore go to the other bank.
//   A DEN gap of any length between words or frames has no effect beyond the IDLE wait.
//   A gap never resets word_idx; only rst or a frame wrap does.
//   disp_bank only changes on a frame wrap.
//     The PWM stage samples it while Vsync is low.
//     A frame in progress never overwrites the bank shown by disp_bank.
//   A frag_err in the middle of a frame does not realign the frame; later words keep counting.
//   Reset asserted mid-word or mid-frame: the partial word/frame is dropped, with no wr_en
//     and no frag_err. Reception restarts at bank 0, word 0.
// TESTING
//   1. Reset, then DEN=1 for 16 cycles with DAI bits of 16'hA5C3 LSB-first ->
//      one wr_en pulse, wr_addr=10'h000, wr_data=16'hA5C3, at cycle 17.
//   2. Two words 16'h1234 and 16'hFFFF with DEN held high for 32 cycles ->
//      wr_en at cycles 17 and 33; addrs 0 and 1; no bit lost.
//   3. DEN high for 7 cycles, then low ->
//      frag_err pulse one cycle later, no wr_en; the next full word is written to addr 0.
//   4. 512 words (word k = k) ->
//      frame_done on the 512th write; disp_bank 1->0 next cycle;
//      word 513 written at wr_addr=10'h200.
//   5. Second frame of 512 words ->
//      disp_bank 0->1; writes return to bank 0; 2048-word run (4 frames) gives alternating banks.
//   6. rst asserted at bit 9 of word 300 ->
//      all outputs at reset values next cycle; the next word is written at addr 0 with disp_bank=1.

Source files
------------

// File: rtl/leddc_serial_rx.sv
// ============================================================================
// Module   : leddc_serial_rx
// Brief    : DAI serial deserializer writing 16-bit words into a double-banked
//            frame buffer; swaps banks and reports the display bank per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leddc_serial_rx #(
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_FRAME = 512,
  parameter int ADDR_W          = 9
) (
  input  logic              DCK,
  input  logic              rst,
  input  logic              DAI,
  input  logic              DEN,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              disp_bank,
  output logic              frag_err
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [DATA_W-1:0]   word_q,       word_d;
  logic [ADDR_W-1:0]   word_idx_q,   word_idx_d;
  logic                bank_q,       bank_d;
  logic                disp_bank_q,  disp_bank_d;
  logic                wr_en_q,      wr_en_d;
  logic [ADDR_W:0]     wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                frag_err_q,   frag_err_d;

  always_ff @(posedge DCK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      bank_q       <= 1'b0;
      disp_bank_q  <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frag_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      bank_q       <= bank_d;
      disp_bank_q  <= disp_bank_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frag_err_q   <= frag_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    bank_d       = bank_q;
    disp_bank_d  = disp_bank_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frag_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (DEN) begin
          word_d    = '0;
          word_d[0] = DAI;
          bit_cnt_d = CNT_W'(1);
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (DEN) begin
          word_d[bit_cnt_q] = DAI;
          if (bit_cnt_q == LAST_BIT) begin
            // Outputs are registered here so they are valid during COMMIT.
            bit_cnt_d    = '0;
            state_d      = S_COMMIT;
            wr_en_d      = 1'b1;
            wr_addr_d    = {bank_q, word_idx_q};
            wr_data_d    = word_d;
            frame_done_d = (word_idx_q == LAST_IDX);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          bit_cnt_d  = '0;
          frag_err_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_COMMIT: begin
        if (frame_done_q) begin
          word_idx_d  = '0;
          disp_bank_d = bank_q;
          bank_d      = ~bank_q;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
        end
        if (DEN) begin
          word_d    = '0;
          word_d[0] = DAI;
          bit_cnt_d = CNT_W'(1);
          state_d   = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign disp_bank  = disp_bank_q;
  assign frag_err   = frag_err_q;

endmodule

`default_nettype wire

// File: tb/tb_leddc_serial_rx.sv
// ============================================================================
// Module   : tb_leddc_serial_rx
// Brief    : Directed self-checking bench for leddc_serial_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leddc_serial_rx;

  logic        clk;
  logic        rst;
  logic        DAI;
  logic        DEN;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        disp_bank;
  logic        frag_err;

  int n_tests;
  int n_fail;

  leddc_serial_rx #(
    .DATA_W          (16),
    .WORDS_PER_FRAME (512),
    .ADDR_W          (9)
  ) u_dut (
    .DCK        (clk),
    .rst        (rst),
    .DAI        (DAI),
    .DEN        (DEN),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .disp_bank  (disp_bank),
    .frag_err   (frag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives 16 bits LSB-first, one per cycle; returns 1ns after the edge
  // that sampled the last bit, i.e. inside the COMMIT cycle.
  task automatic send_word(input logic [15:0] d);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      DEN = 1'b1;
      DAI = d[i];
      @(posedge clk);
    end
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    DEN = 1'b0;
    DAI = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    DEN = 1'b0;
    DAI = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [30:0] obs;
    do_reset();
    @(posedge clk);
    #1;
    obs = {wr_en, wr_addr, wr_data, frame_done, disp_bank, frag_err};
    n_tests++;
    if (obs !== {1'b0, 10'h000, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs,
               {1'b0, 10'h000, 16'h0000, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_single_word();
    logic [15:0] d;
    int early;
    d = 16'hA5C3;
    early = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      DEN = 1'b1;
      DAI = d[i];
      @(posedge clk);
      #1;
      if (i < 15 && wr_en !== 1'b0) early++;
    end
    n_tests++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL single_no_early_wr: got %0d early strobes expected 0", early);
    end
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h000, 16'hA5C3}) begin
      n_fail++;
      $display("FAIL single_write: got en=%b addr=%h data=%h expected en=1 addr=000 data=a5c3",
               wr_en, wr_addr, wr_data);
    end
    idle_cycle();
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 10'h000, 16'hA5C3}) begin
      n_fail++;
      $display("FAIL single_hold: got en=%b addr=%h data=%h expected en=0 addr=000 data=a5c3",
               wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(16'h1234);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h000, 16'h1234}) begin
      n_fail++;
      $display("FAIL b2b_word0: got en=%b addr=%h data=%h expected en=1 addr=000 data=1234",
               wr_en, wr_addr, wr_data);
    end
    send_word(16'hFFFF);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h001, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL b2b_word1: got en=%b addr=%h data=%h expected en=1 addr=001 data=ffff",
               wr_en, wr_addr, wr_data);
    end
    send_word(16'h8001);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h002, 16'h8001}) begin
      n_fail++;
      $display("FAIL b2b_word2: got en=%b addr=%h data=%h expected en=1 addr=002 data=8001",
               wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_fragment();
    int wr_seen;
    wr_seen = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      DEN = 1'b1;
      DAI = 1'b1;
      @(posedge clk);
      #1;
      if (wr_en !== 1'b0) wr_seen++;
    end
    idle_cycle();
    n_tests++;
    if ({frag_err, wr_en} !== 2'b10 || wr_seen != 0) begin
      n_fail++;
      $display("FAIL frag_pulse: got frag=%b en=%b early=%0d expected frag=1 en=0 early=0",
               frag_err, wr_en, wr_seen);
    end
    idle_cycle();
    n_tests++;
    if (frag_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frag_single_cycle: got frag=%b expected 0", frag_err);
    end
    send_word(16'h5A3C);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h000, 16'h5A3C}) begin
      n_fail++;
      $display("FAIL frag_next_word: got en=%b addr=%h data=%h expected en=1 addr=000 data=5a3c",
               wr_en, wr_addr, wr_data);
    end
    idle_cycle();
    idle_cycle();
    idle_cycle();
    send_word(16'h0F0F);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, frag_err} !== {1'b1, 10'h001, 16'h0F0F, 1'b0}) begin
      n_fail++;
      $display("FAIL gap_keeps_index: got en=%b addr=%h data=%h frag=%b expected en=1 addr=001 data=0f0f frag=0",
               wr_en, wr_addr, wr_data, frag_err);
    end
  endtask

  task automatic test_frame_wrap();
    int bad;
    bad = 0;
    do_reset();
    for (int k = 0; k < 512; k++) begin
      send_word(16'(k));
      if ({wr_en, wr_addr, wr_data, frame_done, disp_bank} !==
          {1'b1, 1'b0, 9'(k), 16'(k), (k == 511), 1'b1}) begin
        bad++;
        if (bad < 4)
          $display("FAIL frame0_word%0d: got en=%b addr=%h data=%h fd=%b db=%b expected addr=%h fd=%b db=1",
                   k, wr_en, wr_addr, wr_data, frame_done, disp_bank, 10'(k), (k == 511));
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL frame0_writes: got %0d bad words expected 0", bad);
    end
    idle_cycle();
    n_tests++;
    if ({disp_bank, frame_done, wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL frame0_swap: got db=%b fd=%b en=%b expected db=0 fd=0 en=0",
               disp_bank, frame_done, wr_en);
    end
    send_word(16'd512);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, frame_done, disp_bank} !==
        {1'b1, 10'h200, 16'd512, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL frame1_first: got en=%b addr=%h data=%h fd=%b db=%b expected en=1 addr=200 data=0200 fd=0 db=0",
               wr_en, wr_addr, wr_data, frame_done, disp_bank);
    end
  endtask

  task automatic test_multi_frame();
    logic [12:0] obs;
    logic [12:0] exp_v;
    logic        bank_e;
    int          bad;
    bad = 0;
    do_reset();
    for (int k = 0; k < 2048; k++) begin
      bank_e = ((k / 512) % 2) == 1;
      send_word(16'(k) ^ 16'hC35A);
      obs   = {wr_en, wr_addr, frame_done, disp_bank};
      exp_v = {1'b1, bank_e, 9'(k), (k % 512) == 511, ~bank_e};
      n_tests++;
      if (obs !== exp_v || wr_data !== (16'(k) ^ 16'hC35A)) begin
        n_fail++;
        bad++;
        if (bad < 6)
          $display("FAIL multi_word%0d: got {en,addr,fd,db}=%h data=%h expected %h data=%h",
                   k, obs, wr_data, exp_v, 16'(k) ^ 16'hC35A);
      end
    end
    idle_cycle();
    n_tests++;
    if (disp_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_final_bank: got db=%b expected 1", disp_bank);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    logic [30:0] obs;
    d = 16'hBEEF;
    do_reset();
    for (int k = 0; k < 812; k++) send_word(16'(k));
    n_tests++;
    if ({wr_addr, disp_bank} !== {1'b1, 9'd299, 1'b0}) begin
      n_fail++;
      $display("FAIL premid_state: got addr=%h db=%b expected addr=32b db=0", wr_addr, disp_bank);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      DEN = 1'b1;
      DAI = d[i];
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    DEN = 1'b1;
    DAI = d[9];
    @(posedge clk);
    #1;
    obs = {wr_en, wr_addr, wr_data, frame_done, disp_bank, frag_err};
    n_tests++;
    if (obs !== {1'b0, 10'h000, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_state: got %h expected %h", obs,
               {1'b0, 10'h000, 16'h0000, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    DEN = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({frag_err, wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_no_frag: got frag=%b en=%b expected 0 0", frag_err, wr_en);
    end
    send_word(16'h2468);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, disp_bank} !== {1'b1, 10'h000, 16'h2468, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_restart: got en=%b addr=%h data=%h db=%b expected en=1 addr=000 data=2468 db=1",
               wr_en, wr_addr, wr_data, disp_bank);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    DEN = 1'b0;
    DAI = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fragment();
    test_frame_wrap();
    test_multi_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
